btn_cond: RTL and testbench

BTN_COND -- requirements
Module: btn_cond

---
 rtl/btn_cond.sv | 186 ++++++++++++++++++
 tb/tb_btn_cond.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cond.sv
// Five-button synchronizer, per-button debouncer and single-press classifier (IDLE/HELD/ERR).
// Define BTN_HOLD_REPEAT_EN to re-pulse press_valid every RPT_CYCLES while one button stays held.
// The release pulse is on port release_pulse because "release" is a reserved word.
module btn_cond #(
    parameter logic [15:0] DB_CYCLES  = 16'd50000,
    parameter logic [23:0] RPT_CYCLES = 24'd5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnR,
    input  logic       btnM,
    input  logic       btnL,
    input  logic       btnU,
    input  logic       btnD,
    output logic [4:0] btn_lvl,
    output logic       press_valid,
    output logic [2:0] press_code,
    output logic       release_pulse,
    output logic       multi_err,
    output logic       busy
);
    // state | meaning
    // IDLE  | no button accepted, waiting for exactly one debounced level
    // HELD  | one button accepted (press_code), waiting for its release
    // ERR   | more than one button seen, waiting for all levels to drop
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        ERR  = 2'd2
    } state_t;

    logic [4:0]       raw;
    logic [4:0]       sync1_q;
    logic [4:0]       sync2_q;
    logic [4:0]       lvl_q;
    logic [4:0]       lvl_d;
    logic [4:0][15:0] db_cnt_q;
    logic [4:0][15:0] db_cnt_d;

    state_t           state_q;
    state_t           state_d;
    logic             pv_q;
    logic             pv_d;
    logic             rel_q;
    logic             rel_d;
    logic             me_q;
    logic             me_d;
    logic             busy_q;
    logic             busy_d;
    logic [2:0]       code_q;
    logic [2:0]       code_d;

    logic [2:0]       pop;
    logic [2:0]       enc;
    logic [4:0]       held_mask;

`ifdef BTN_HOLD_REPEAT_EN
    logic [23:0]      rpt_cnt_q;
    logic [23:0]      rpt_cnt_d;
`endif

    assign raw = {btnD, btnU, btnL, btnM, btnR};

    always_comb begin
        lvl_d    = lvl_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == lvl_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_CYCLES - 16'd1) begin
                db_cnt_d[i] = '0;
                lvl_d[i]    = ~lvl_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        pop = '0;
        enc = '0;
        for (int i = 0; i < 5; i++) begin
            pop = pop + {2'b00, lvl_q[i]};
        end
        for (int i = 4; i >= 0; i--) begin
            if (lvl_q[i]) begin
                enc = 3'(i + 1);
            end
        end
    end

    // press_code identifies the accepted button while in HELD
    assign held_mask = (code_q == 3'd0) ? 5'd0 : (5'd1 << (code_q - 3'd1));

    always_comb begin
        state_d = state_q;
        pv_d    = 1'b0;
        rel_d   = 1'b0;
        me_d    = 1'b0;
        code_d  = code_q;
`ifdef BTN_HOLD_REPEAT_EN
        rpt_cnt_d = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pop == 3'd1) begin
                    state_d = HELD;
                    pv_d    = 1'b1;
                    code_d  = enc;
                end else if (pop > 3'd1) begin
                    state_d = ERR;
                    me_d    = 1'b1;
                end
            end
            HELD: begin
                if (lvl_q == 5'd0) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                end else if (lvl_q != held_mask) begin
                    state_d = ERR;
                    me_d    = 1'b1;
                end
`ifdef BTN_HOLD_REPEAT_EN
                else if (rpt_cnt_q == RPT_CYCLES - 24'd1) begin
                    pv_d = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 24'd1;
                end
`endif
            end
            ERR: begin
                if (lvl_q == 5'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            db_cnt_q <= '0;
            state_q  <= IDLE;
            pv_q     <= 1'b0;
            rel_q    <= 1'b0;
            me_q     <= 1'b0;
            busy_q   <= 1'b0;
            code_q   <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            lvl_q    <= lvl_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            pv_q     <= pv_d;
            rel_q    <= rel_d;
            me_q     <= me_d;
            busy_q   <= busy_d;
            code_q   <= code_d;
        end
    end

`ifdef BTN_HOLD_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`endif

    assign btn_lvl       = lvl_q;
    assign press_valid   = pv_q;
    assign press_code    = code_q;
    assign release_pulse = rel_q;
    assign multi_err     = me_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_btn_cond.sv
// Randomized and directed bench for btn_cond, checked every cycle against a window-based model.
module tb_btn_cond;
    localparam int DB  = 4;
    localparam int RPT = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] raw = 5'd0;
    logic [4:0] btn_lvl;
    logic       press_valid;
    logic [2:0] press_code;
    logic       release_pulse;
    logic       multi_err;
    logic       busy;

    btn_cond #(.DB_CYCLES(16'(DB)), .RPT_CYCLES(24'(RPT))) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btnR(raw[0]),
        .btnM(raw[1]),
        .btnL(raw[2]),
        .btnU(raw[3]),
        .btnD(raw[4]),
        .btn_lvl(btn_lvl),
        .press_valid(press_valid),
        .press_code(press_code),
        .release_pulse(release_pulse),
        .multi_err(multi_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a level flips once the last DB synchronized samples all disagree with it.
    bit [4:0] hist [0:DB];
    bit [4:0] m_lvl;
    bit       m_pv, m_rel, m_me, m_err, m_busy;
    bit [2:0] m_code;
    int       m_acc = -1;
    int       m_held;

    task automatic model_reset();
        for (int j = 0; j <= DB; j++) hist[j] = '0;
        m_lvl = '0; m_pv = 0; m_rel = 0; m_me = 0; m_err = 0; m_busy = 0;
        m_code = '0; m_acc = -1; m_held = 0;
    endtask

    task automatic model_step();
        int  cnt;
        bit  all_diff;
        cnt = $countones(m_lvl);
        m_pv = 0; m_rel = 0; m_me = 0;
        if (m_err) begin
            if (m_lvl == 0) m_err = 0;
        end else if (m_acc < 0) begin
            if (cnt == 1) begin
                for (int b = 0; b < 5; b++) if (m_lvl[b]) m_acc = b;
                m_pv = 1; m_code = 3'(m_acc + 1); m_held = 0;
            end else if (cnt > 1) begin
                m_err = 1; m_me = 1;
            end
        end else begin
            if (m_lvl == 0) begin
                m_rel = 1; m_acc = -1;
            end else if (m_lvl != (5'b1 << m_acc)) begin
                m_err = 1; m_me = 1; m_acc = -1;
            end else begin
`ifdef BTN_HOLD_REPEAT_EN
                m_held++;
                if (m_held == RPT) begin
                    m_pv = 1; m_held = 0;
                end
`endif
            end
        end
        m_busy = m_err || (m_acc >= 0);
        for (int b = 0; b < 5; b++) begin
            all_diff = 1;
            for (int j = 1; j <= DB; j++) if (hist[j][b] == m_lvl[b]) all_diff = 0;
            if (all_diff) m_lvl[b] = ~m_lvl[b];
        end
        for (int j = DB; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = raw;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int s;
        chk("btn_lvl", 32'(btn_lvl), 32'(m_lvl));
        chk("press_valid", 32'(press_valid), 32'(m_pv));
        chk("press_code", 32'(press_code), 32'(m_code));
        chk("release", 32'(release_pulse), 32'(m_rel));
        chk("multi_err", 32'(multi_err), 32'(m_me));
        chk("busy", 32'(busy), 32'(m_busy));
        s = int'(press_valid) + int'(release_pulse) + int'(multi_err);
        chk("pulse_excl", 32'(s <= 1), 32'd1);
    end

    int       n_pv, n_rel, n_me;
    bit [4:0] lvl_or;
    int       pv_cycs [$];

    always @(negedge clk) begin
        if (press_valid) begin
            n_pv++;
            pv_cycs.push_back(cyc);
        end
        if (release_pulse) n_rel++;
        if (multi_err) n_me++;
        lvl_or |= btn_lvl;
    end

    task automatic clr_mon();
        n_pv = 0; n_rel = 0; n_me = 0; lvl_or = '0;
        pv_cycs.delete();
    endtask

    task automatic idle(input int n);
        raw = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int rel_k;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({btn_lvl, press_valid, press_code, release_pulse, multi_err, busy}), 32'd0);
        rst_n = 1'b1;
        idle(4);

        // clean btnR press: level at edge 6, press at edge 7
        clr_mon();
        raw = 5'b00001;
        repeat (5) @(negedge clk);
        chk("r_lvl_edge5", 32'(btn_lvl[0]), 32'd0);
        @(negedge clk);
        chk("r_lvl_edge6", 32'(btn_lvl[0]), 32'd1);
        chk("r_pv_edge6", 32'(press_valid), 32'd0);
        @(negedge clk);
        chk("r_pv_edge7", 32'(press_valid), 32'd1);
        chk("r_code_edge7", 32'(press_code), 32'd1);
        chk("r_busy_edge7", 32'(busy), 32'd1);
        @(negedge clk);
        chk("r_pv_edge8", 32'(press_valid), 32'd0);
        idle(12);

        // btnU glitch of 3 synchronized cycles
        clr_mon();
        raw = 5'b01000;
        repeat (3) @(negedge clk);
        idle(12);
        chk("glitch_lvl", 32'(lvl_or), 32'd0);
        chk("glitch_pv", 32'(n_pv), 32'd0);
        chk("glitch_me", 32'(n_me), 32'd0);

        // btnL held then btnD added
        clr_mon();
        raw = 5'b00100;
        repeat (10) @(negedge clk);
        chk("l_pv_count", 32'(n_pv), 32'd1);
        chk("l_code", 32'(press_code), 32'd3);
        raw = 5'b10100;
        repeat (10) @(negedge clk);
        chk("ld_me_count", 32'(n_me), 32'd1);
        idle(10);
        chk("ld_no_release", 32'(n_rel), 32'd0);
        chk("ld_busy", 32'(busy), 32'd0);
        chk("ld_no_press_err", 32'(n_pv), 32'd1);

        // btnM press and clean release: release 7 edges after the release edge
        clr_mon();
        raw = 5'b00010;
        repeat (10) @(negedge clk);
        raw = 5'b00000;
        rel_k = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (release_pulse && rel_k == 0) rel_k = k;
        end
        chk("m_release_latency", 32'(rel_k), 32'd7);
        chk("m_code_hold", 32'(press_code), 32'd2);
        chk("m_release_count", 32'(n_rel), 32'd1);

        // reset while btnD held
        clr_mon();
        raw = 5'b10000;
        repeat (10) @(negedge clk);
        chk("d_pv_before_rst", 32'(n_pv), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("d_rst_outputs", 32'({btn_lvl, press_valid, press_code, release_pulse, multi_err, busy}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr_mon();
        repeat (12) @(negedge clk);
        chk("d_pv_after_rst", 32'(n_pv), 32'd1);
        chk("d_code_after_rst", 32'(press_code), 32'd5);
        chk("d_no_release", 32'(n_rel), 32'd0);
        idle(12);

        // long btnR hold
        clr_mon();
        raw = 5'b00001;
        repeat (78) @(negedge clk);
`ifdef BTN_HOLD_REPEAT_EN
        chk("rpt_count", 32'(n_pv), 32'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < pv_cycs.size()) chk("rpt_offset", 32'(pv_cycs[i] - pv_cycs[0]), 32'(RPT * i));
        end
`else
        chk("hold_single_press", 32'(n_pv), 32'd1);
`endif
        chk("hold_code", 32'(press_code), 32'd1);
        idle(12);

        // randomized segments
        for (int seg = 0; seg < 400; seg++) begin
            int len;
            int sel;
            sel = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, (sel == 9) ? 45 : 14));
            if (sel < 3) raw = '0;
            else if (sel < 8) raw = 5'b1 << $urandom_range(0, 4);
            else raw = 5'($urandom);
            if (seg % 97 == 50) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (len) @(negedge clk);
        end
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
